i2c_regfile_slave: RTL and testbench

Parametrised I2C target (slave) that exposes a bank of 8-bit registers to an I2C controller, using a register pointer that auto-increments and wraps.
- Supports write bursts, pointer-then-read via repeated START, NACK of foreign addresses, and master-NACK termination of read bursts.
- Adds an input glitch filter.
- Sits between the open-drain pad logic (SCL/SDA pull-low enables) and a fabric-side register file, via simple strobe interfaces.
- Runs on the 10 MHz system clock.

---
 rtl/i2c_regfile_slave.sv | 168 ++++++++++++++++
 tb/tb_i2c_regfile_slave.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/i2c_regfile_slave.sv
// i2c_regfile_slave: I2C target with glitch-filtered inputs exposing an auto-incrementing 8-bit register bank
`timescale 1ns/1ps
module i2c_regfile_slave #(
  parameter logic [6:0] I2C_ADDRESS = 7'h42,
  parameter int PTR_W = 4,
  parameter int FILTER_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_di,
  input  logic             sda_di,
  output logic             scl_ndo,
  output logic             sda_ndo,
  output logic             reg_wr_stb,
  output logic [PTR_W-1:0] reg_wr_addr,
  output logic [7:0]       reg_wr_data,
  output logic             reg_rd_stb,
  output logic [PTR_W-1:0] reg_rd_addr,
  input  logic [7:0]       reg_rd_data,
  output logic             busy,
  output logic             stop_stb,
  output logic             error_stb
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RD_LOAD, RDATA, RACK, WAIT_STOP, IGNORE
  } state_e;
  // bit 0 carries SCL, bit 1 carries SDA
  logic [1:0] s1_q, s2_q, filt_q, prev_q;
  logic [1:0][2:0] cnt_q;
  state_e state_q;
  logic [3:0] bit_q;
  logic [7:0] sh_q;
  logic [PTR_W-1:0] ptr_q, wr_addr_q, rd_addr_q;
  logic [7:0] wr_data_q;
  logic rw_q, rd_wait_q, sda_q, wr_stb_q, rd_stb_q, busy_q, stop_q, err_q;
  logic scl_rise, scl_fall, start, stop, in_byte, abort, rx_done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
      filt_q <= '1;
      prev_q <= '1;
      cnt_q <= '0;
    end else begin
      s1_q <= {sda_di, scl_di};
      s2_q <= s1_q;
      prev_q <= filt_q;
      for (int i = 0; i < 2; i++)
        if (s2_q[i] == filt_q[i]) cnt_q[i] <= '0;
        else if (cnt_q[i] == 3'(FILTER_LEN - 1)) begin
          filt_q[i] <= s2_q[i];
          cnt_q[i] <= '0;
        end else cnt_q[i] <= cnt_q[i] + 3'd1;
    end
  assign scl_rise = filt_q[0] & ~prev_q[0];
  assign scl_fall = ~filt_q[0] & prev_q[0];
  assign start = filt_q[0] & prev_q[0] & prev_q[1] & ~filt_q[1];
  assign stop = filt_q[0] & prev_q[0] & ~prev_q[1] & filt_q[1];
  assign in_byte = state_q inside {ADDR, PTR, WDATA, RDATA};
  // one SCL rise always precedes a legal START/STOP, so only two or more bits mark a truncated byte
  assign abort = busy_q & in_byte & (bit_q >= 4'd2);
  assign rx_done = scl_fall & (bit_q == 4'd8);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q <= '0;
      sh_q <= '0;
      ptr_q <= '0;
      rw_q <= 1'b0;
      rd_wait_q <= 1'b0;
      sda_q <= 1'b0;
      wr_stb_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_stb_q <= 1'b0;
      rd_addr_q <= '0;
      busy_q <= 1'b0;
      stop_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
      stop_q <= 1'b0;
      err_q <= 1'b0;
      if (start || stop) begin
        err_q <= abort;
        stop_q <= stop & busy_q;
        busy_q <= busy_q & start;
        state_q <= start ? ADDR : IDLE;
        bit_q <= '0;
        sda_q <= 1'b0;
        rd_wait_q <= 1'b0;
      end else begin
        if (scl_rise && in_byte) bit_q <= bit_q + 4'd1;
        if (scl_rise && state_q inside {ADDR, PTR, WDATA}) sh_q <= {sh_q[6:0], filt_q[1]};
        case (state_q)
          ADDR: if (rx_done) begin
            bit_q <= '0;
            if (sh_q[7:1] == I2C_ADDRESS) begin
              state_q <= ADDR_ACK;
              rw_q <= sh_q[0];
              sda_q <= 1'b1;
              busy_q <= 1'b1;
            end else state_q <= IGNORE;
          end
          PTR: if (rx_done) begin
            bit_q <= '0;
            ptr_q <= sh_q[PTR_W-1:0];
            sda_q <= 1'b1;
            state_q <= PTR_ACK;
          end
          WDATA: if (rx_done) begin
            bit_q <= '0;
            wr_stb_q <= 1'b1;
            wr_addr_q <= ptr_q;
            wr_data_q <= sh_q;
            ptr_q <= ptr_q + PTR_W'(1);
            sda_q <= 1'b1;
            state_q <= WDATA_ACK;
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
            sda_q <= 1'b0;
            bit_q <= '0;
            state_q <= state_q == ADDR_ACK ? (rw_q ? RD_LOAD : PTR) : WDATA;
          end
          // strobe, wait one cycle for the register file, then capture and present the MSB
          RD_LOAD: if (rd_stb_q) rd_wait_q <= 1'b1;
          else if (rd_wait_q) begin
            rd_wait_q <= 1'b0;
            sh_q <= reg_rd_data;
            sda_q <= ~reg_rd_data[7];
            ptr_q <= ptr_q + PTR_W'(1);
            bit_q <= '0;
            state_q <= RDATA;
          end else begin
            rd_stb_q <= 1'b1;
            rd_addr_q <= ptr_q;
          end
          RDATA: if (rx_done) begin
            sda_q <= 1'b0;
            bit_q <= '0;
            state_q <= RACK;
          end else if (scl_fall) begin
            sh_q <= {sh_q[6:0], 1'b0};
            sda_q <= ~sh_q[6];
          end
          RACK: if (scl_rise) begin
            if (filt_q[1]) state_q <= WAIT_STOP;
            else bit_q <= 4'd1;
          end else if (scl_fall && bit_q == 4'd1) begin
            bit_q <= '0;
            state_q <= RD_LOAD;
          end
          default: ;
        endcase
      end
    end
  assign scl_ndo = 1'b0;
  assign sda_ndo = sda_q;
  assign reg_wr_stb = wr_stb_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign reg_rd_stb = rd_stb_q;
  assign reg_rd_addr = rd_addr_q;
  assign busy = busy_q;
  assign stop_stb = stop_q;
  assign error_stb = err_q;
endmodule

// File: tb/tb_i2c_regfile_slave.sv
// tb_i2c_regfile_slave: bit-banged I2C controller with write/read scoreboards for i2c_regfile_slave
`timescale 1ns/1ps
module tb_i2c_regfile_slave;
  localparam int Q = 10;
  logic clk = 1'b0, rst_n = 1'b0;
  logic scl_m = 1'b1, sda_m = 1'b1, glitch = 1'b0;
  logic scl_ndo, sda_ndo, reg_wr_stb, reg_rd_stb, busy, stop_stb, error_stb;
  logic [3:0] reg_wr_addr, reg_rd_addr;
  logic [7:0] reg_wr_data, reg_rd_data;
  logic [7:0] regs [16];
  logic sda_line, scl_line;
  int n_chk = 0, n_pass = 0;
  int wr_n = 0, rd_n = 0, stop_n = 0, err_n = 0, ndo_n = 0, busy_n = 0;
  int w0, r0, s0, e0, d0, b0;
  logic [11:0] wq [$];
  logic [7:0] rq [$];
  assign sda_line = sda_m & ~sda_ndo;
  assign scl_line = scl_m & ~scl_ndo;
  assign reg_rd_data = regs[reg_rd_addr];
  i2c_regfile_slave #(.I2C_ADDRESS(7'h42), .PTR_W(4), .FILTER_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .scl_di(scl_line), .sda_di(sda_line & ~glitch),
    .scl_ndo(scl_ndo), .sda_ndo(sda_ndo),
    .reg_wr_stb(reg_wr_stb), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
    .reg_rd_stb(reg_rd_stb), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .busy(busy), .stop_stb(stop_stb), .error_stb(error_stb)
  );
  always #50 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got %h expected %h", tag, got, exp);
  endtask
  // event counters plus the write scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    ndo_n += int'(sda_ndo);
    busy_n += int'(busy);
    rd_n += int'(reg_rd_stb);
    stop_n += int'(stop_stb);
    err_n += int'(error_stb);
    if (reg_wr_stb) begin
      wr_n++;
      chk("wr_expected", 16'(wq.size() != 0), 16'd1);
      if (wq.size() != 0) chk("wr_addr_data", {4'h0, reg_wr_addr, reg_wr_data}, {4'h0, wq.pop_front()});
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic start_c();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask
  task automatic stop_c();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask
  task automatic bit_w(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask
  task automatic bit_r(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask
  task automatic wr_byte(input logic [7:0] d, input logic exp_ack, input string tag);
    logic a;
    for (int i = 7; i >= 0; i--) bit_w(d[i]);
    bit_r(a);
    chk(tag, 16'(a), 16'(exp_ack));
  endtask
  task automatic rd_byte(input logic nack, input string tag);
    logic [7:0] d;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_r(b);
      d[i] = b;
    end
    bit_w(nack);
    chk(tag, 16'(d), 16'(rq.pop_front()));
  endtask
  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'h10 + 8'(i);
    tick(3);
    chk("rst_ctrl", {9'h0, scl_ndo, sda_ndo, reg_wr_stb, reg_rd_stb, busy, stop_stb, error_stb}, 16'h0);
    chk("rst_wr_bus", {4'h0, reg_wr_addr, reg_wr_data}, 16'h0);
    chk("rst_rd_addr", 16'(reg_rd_addr), 16'h0);
    rst_n = 1'b1;
    tick(5);
    // write burst from register 3
    w0 = wr_n; s0 = stop_n;
    start_c();
    wr_byte(8'h84, 1'b0, "t1_addr_ack");
    wr_byte(8'h03, 1'b0, "t1_ptr_ack");
    wq.push_back({4'h3, 8'hA5});
    wr_byte(8'hA5, 1'b0, "t1_d0_ack");
    chk("t1_busy_during", 16'(busy), 16'd1);
    wq.push_back({4'h4, 8'h5A});
    wr_byte(8'h5A, 1'b0, "t1_d1_ack");
    stop_c();
    chk("t1_wr_count", 16'(wr_n - w0), 16'd2);
    chk("t1_stop_stb", 16'(stop_n - s0), 16'd1);
    chk("t1_busy_after", 16'(busy), 16'd0);
    chk("t1_wq_empty", 16'(wq.size()), 16'd0);
    // pointer then repeated-START read burst wrapping past the top
    r0 = rd_n;
    start_c();
    wr_byte(8'h84, 1'b0, "t2_addr_ack");
    wr_byte(8'h0E, 1'b0, "t2_ptr_ack");
    start_c();
    wr_byte(8'h85, 1'b0, "t2_raddr_ack");
    rq.push_back(8'h1E);
    rd_byte(1'b0, "t2_rd0");
    rq.push_back(8'h1F);
    rd_byte(1'b0, "t2_rd1");
    rq.push_back(8'h10);
    rd_byte(1'b1, "t2_rd2_wrap");
    stop_c();
    chk("t2_rd_count", 16'(rd_n - r0), 16'd3);
    chk("t2_busy_after", 16'(busy), 16'd0);
    start_c();
    wr_byte(8'h85, 1'b0, "t2b_raddr_ack");
    rq.push_back(8'h11);
    rd_byte(1'b1, "t2b_ptr_is_1");
    stop_c();
    // foreign address is never acknowledged
    w0 = wr_n; r0 = rd_n; s0 = stop_n; d0 = ndo_n; b0 = busy_n;
    start_c();
    wr_byte(8'h90, 1'b1, "t3_addr_nack");
    wr_byte(8'h12, 1'b1, "t3_b0_nack");
    wr_byte(8'h34, 1'b1, "t3_b1_nack");
    stop_c();
    chk("t3_ndo_never", 16'(ndo_n - d0), 16'd0);
    chk("t3_no_strobes", 16'(wr_n - w0 + rd_n - r0 + stop_n - s0), 16'd0);
    chk("t3_busy_never", 16'(busy_n - b0), 16'd0);
    // STOP four bits into a data byte
    w0 = wr_n; e0 = err_n;
    start_c();
    wr_byte(8'h84, 1'b0, "t4_addr_ack");
    wr_byte(8'h05, 1'b0, "t4_ptr_ack");
    bit_w(1'b1); bit_w(1'b1); bit_w(1'b0); bit_w(1'b0);
    stop_c();
    chk("t4_error_once", 16'(err_n - e0), 16'd1);
    chk("t4_no_write", 16'(wr_n - w0), 16'd0);
    chk("t4_busy_after", 16'(busy), 16'd0);
    start_c();
    wr_byte(8'h84, 1'b0, "t4b_addr_ack");
    wr_byte(8'h07, 1'b0, "t4b_ptr_ack");
    wq.push_back({4'h7, 8'h3C});
    wr_byte(8'h3C, 1'b0, "t4b_d_ack");
    stop_c();
    chk("t4b_wr_count", 16'(wr_n - w0), 16'd1);
    chk("t4b_no_new_error", 16'(err_n - e0), 16'd1);
    // one-cycle SDA glitch with SCL high must not look like START
    s0 = stop_n; d0 = ndo_n; b0 = busy_n;
    glitch = 1'b1; tick(1);
    glitch = 1'b0; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
    wr_byte(8'h84, 1'b1, "t5_no_start_nack");
    stop_c();
    chk("t5_ndo_never", 16'(ndo_n - d0), 16'd0);
    chk("t5_busy_never", 16'(busy_n - b0), 16'd0);
    chk("t5_no_stop_stb", 16'(stop_n - s0), 16'd0);
    // reset while the target drives a 0 data bit
    start_c();
    wr_byte(8'h84, 1'b0, "t6_addr_ack");
    wr_byte(8'h00, 1'b0, "t6_ptr_ack");
    start_c();
    wr_byte(8'h85, 1'b0, "t6_raddr_ack");
    tick(Q);
    chk("t6_msb0_driven", 16'(sda_ndo), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_release_same_cycle", 16'(sda_ndo), 16'd0);
    chk("t6_busy_reset", 16'(busy), 16'd0);
    tick(2);
    rst_n = 1'b1;
    sda_m = 1'b1;
    scl_m = 1'b1;
    tick(2 * Q);
    start_c();
    wr_byte(8'h85, 1'b0, "t6b_raddr_ack");
    rq.push_back(8'h10);
    rd_byte(1'b1, "t6b_ptr_is_0");
    stop_c();
    chk("final_wq_empty", 16'(wq.size()), 16'd0);
    chk("final_rq_empty", 16'(rq.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
